// File: rtl/riscv_pkg.sv
// Shared writeback-stage definitions: result-source encodings, load funct3 codes,
// stage FSM state type and load extension helpers.
package riscv_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_NONE = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// load_extend: lane select and sign/zero extension of an aligned memory word;
// flags misaligned halfword/word accesses and unknown funct3 codes.
import riscv_pkg::*;

module load_extend (
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (funct3)
            F3_LB:  data = ext_byte(lane_b, 1'b1);
            F3_LBU: data = ext_byte(lane_b, 1'b0);
            F3_LH: begin
                data = ext_half(lane_h, 1'b1);
                err  = addr_lo[0];
            end
            F3_LHU: begin
                data = ext_half(lane_h, 1'b0);
                err  = addr_lo[0];
            end
            F3_LW: begin
                data = word;
                err  = (addr_lo != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/link results in one cycle, waits for load data.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter port.
//
// state        | meaning
// WB_IDLE      | ready for a retiring instruction from MEM
// WB_WAIT_LOAD | load captured, waiting for mem_rsp_valid (or flush)
import riscv_pkg::*;

module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus4,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        flush,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [4:0]  rd,
    output logic [31:0] rd_data,
    output logic        reg_write,
    output logic        err_misaligned
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    wb_state_e   state_q, state_d;

    logic [4:0]  ld_rd_q;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_addr_lo_q;
    logic        ld_reg_write_q;

    logic        accept;
    logic        capture_load;
    logic        retire;
    logic        wr_d;
    logic        err_d;
    logic [4:0]  rd_d;
    logic [31:0] data_d;
    logic [31:0] ld_data;
    logic        ld_err;

    load_extend u_load_extend (
        .word    (mem_rsp_data),
        .funct3  (ld_funct3_q),
        .addr_lo (ld_addr_lo_q),
        .data    (ld_data),
        .err     (ld_err)
    );

    assign in_ready = (state_q == WB_IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WB_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        capture_load = 1'b0;
        retire       = 1'b0;
        wr_d         = 1'b0;
        err_d        = 1'b0;
        rd_d         = rd;
        data_d       = rd_data;
        case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    case (in_wb_sel)
                        WB_SEL_ALU, WB_SEL_PC4: begin
                            retire = 1'b1;
                            rd_d   = in_rd;
                            data_d = (in_wb_sel == WB_SEL_ALU) ? in_alu_result : in_pc_plus4;
                            wr_d   = in_reg_write;
                        end
                        WB_SEL_NONE: retire = 1'b1;
                        default: begin
                            capture_load = 1'b1;
                            state_d      = WB_WAIT_LOAD;
                        end
                    endcase
                end
            end
            WB_WAIT_LOAD: begin
                // flush wins over a coincident response: the load is dropped silently
                if (flush) begin
                    state_d = WB_IDLE;
                end else if (mem_rsp_valid) begin
                    state_d = WB_IDLE;
                    retire  = 1'b1;
                    rd_d    = ld_rd_q;
                    if (ld_err) begin
                        err_d = 1'b1;
                    end else begin
                        data_d = ld_data;
                        wr_d   = ld_reg_write_q;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rd_q        <= '0;
            ld_funct3_q    <= '0;
            ld_addr_lo_q   <= '0;
            ld_reg_write_q <= 1'b0;
        end else if (capture_load) begin
            ld_rd_q        <= in_rd;
            ld_funct3_q    <= in_funct3;
            ld_addr_lo_q   <= in_addr_lo;
            ld_reg_write_q <= in_reg_write;
        end
    end

    // x0 is hardwired: the data still goes out, the enable never does
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd             <= '0;
            rd_data        <= '0;
            reg_write      <= 1'b0;
            err_misaligned <= 1'b0;
        end else begin
            rd             <= rd_d;
            rd_data        <= data_d;
            reg_write      <= wr_d && (rd_d != 5'd0);
            err_misaligned <= err_d;
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret <= '0;
        else if (retire) instret <= instret + 64'd1;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed examples plus randomized traffic
// against a transaction-level reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        flush;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        reg_write;
    logic        err_misaligned;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_wb_sel      (in_wb_sel),
        .in_alu_result  (in_alu_result),
        .in_pc_plus4    (in_pc_plus4),
        .in_funct3      (in_funct3),
        .in_addr_lo     (in_addr_lo),
        .flush          (flush),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .rd             (rd),
        .rd_data        (rd_data),
        .reg_write      (reg_write),
        .err_misaligned (err_misaligned)
`ifdef WB_INSTRET_EN
        ,
        .instret        (instret)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: one outstanding load at most
    bit          m_busy;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_a;
    bit          m_rw;
    longint      m_instret;
    bit          exp_wr, exp_err, cmp;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // returns {err, data}
    function automatic logic [32:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [31:0] s;
        s = w >> (int'(a) * 8);
        case (f3)
            3'b000: return {1'b0, {{24{s[7]}}, s[7:0]}};
            3'b100: return {1'b0, 24'd0, s[7:0]};
            3'b001, 3'b101: begin
                if (a[0]) return {1'b1, 32'd0};
                s = w >> (int'(a[1]) * 16);
                if (f3 == 3'b001) return {1'b0, {{16{s[15]}}, s[15:0]}};
                return {1'b0, 16'd0, s[15:0]};
            end
            3'b010: begin
                if (a != 2'b00) return {1'b1, 32'd0};
                return {1'b0, w};
            end
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic drive(input logic v, input logic [4:0] r, input logic rw, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [1:0] a, input logic fl, input logic rv, input logic [31:0] rdat);
        in_valid      = v;
        in_rd         = r;
        in_reg_write  = rw;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc_plus4   = pc;
        in_funct3     = f3;
        in_addr_lo    = a;
        flush         = fl;
        mem_rsp_valid = rv;
        mem_rsp_data  = rdat;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_instret = 0;
    endtask

    // called at a falling edge right after drive(); ends at the next falling edge
    task automatic step();
        logic [32:0] f;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_busy && !flush)});
        exp_wr = 1'b0; exp_err = 1'b0; cmp = 1'b0;
        if (!m_busy) begin
            if (in_valid && !flush) begin
                case (in_wb_sel)
                    2'b00, 2'b10: begin
                        cmp      = 1'b1;
                        exp_rd   = in_rd;
                        exp_data = (in_wb_sel == 2'b00) ? in_alu_result : in_pc_plus4;
                        exp_wr   = in_reg_write && (in_rd != 0);
                        m_instret++;
                    end
                    2'b11: m_instret++;
                    default: begin
                        m_busy = 1'b1;
                        m_rd   = in_rd;
                        m_f3   = in_funct3;
                        m_a    = in_addr_lo;
                        m_rw   = in_reg_write;
                    end
                endcase
            end
        end else if (flush) begin
            m_busy = 1'b0;
        end else if (mem_rsp_valid) begin
            f = ref_load(mem_rsp_data, m_f3, m_a);
            m_busy = 1'b0;
            m_instret++;
            if (f[32]) exp_err = 1'b1;
            else begin
                cmp      = 1'b1;
                exp_rd   = m_rd;
                exp_data = f[31:0];
                exp_wr   = m_rw && (m_rd != 0);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("reg_write", {63'd0, reg_write}, {63'd0, exp_wr});
        chk("err_misaligned", {63'd0, err_misaligned}, {63'd0, exp_err});
        if (cmp) begin
            chk("rd", {59'd0, rd}, {59'd0, exp_rd});
            chk("rd_data", {32'd0, rd_data}, {32'd0, exp_data});
        end
`ifdef WB_INSTRET_EN
        chk("instret", instret, m_instret);
`endif
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd"}, {59'd0, rd}, 64'd0);
        chk({tag, "_rd_data"}, {32'd0, rd_data}, 64'd0);
        chk({tag, "_reg_write"}, {63'd0, reg_write}, 64'd0);
        chk({tag, "_err"}, {63'd0, err_misaligned}, 64'd0);
    endtask

    task automatic load_with_rsp(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] r,
                                 input int wait_cycles, input logic [31:0] word);
        drive(1'b1, r, 1'b1, 2'b01, 32'd0, 32'd0, f3, a, 1'b0, 1'b0, 32'd0);
        step();
        for (int i = 0; i < wait_cycles; i++) begin
            // upstream keeps offering an ALU op that must not be taken
            drive(1'b1, 5'd3, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0);
            step();
        end
        drive(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b1, word);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ALU example
        drive(1'b1, 5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0);
        step();
        chk("ex_alu_wr", {63'd0, reg_write}, 64'd1);
        chk("ex_alu_data", {32'd0, rd_data}, 64'h0000_1234);

        // LB / LBU on the top byte, response three cycles later
        load_with_rsp(3'b000, 2'd3, 5'd7, 3, 32'h80FF_0000);
        chk("ex_lb", {32'd0, rd_data}, 64'hFFFF_FF80);
        load_with_rsp(3'b100, 2'd3, 5'd7, 3, 32'h80FF_0000);
        chk("ex_lbu", {32'd0, rd_data}, 64'h0000_0080);

        // misaligned LH, then LHU on the upper half
        load_with_rsp(3'b001, 2'd1, 5'd8, 1, 32'h1234_5678);
        chk("ex_lh_err", {63'd0, err_misaligned}, 64'd1);
        idle();
        step();
        load_with_rsp(3'b101, 2'd2, 5'd8, 0, 32'h8001_0000);
        chk("ex_lhu", {32'd0, rd_data}, 64'h0000_8001);

        // x0 write suppressed, JAL link
        drive(1'b1, 5'd0, 1'b1, 2'b00, 32'hCAFE_0001, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0);
        step();
        chk("ex_x0_wr", {63'd0, reg_write}, 64'd0);
        drive(1'b1, 5'd1, 1'b1, 2'b10, 32'd0, 32'h0000_0104, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0);
        step();
        chk("ex_jal", {32'd0, rd_data}, 64'h0000_0104);

        // flush in IDLE blocks acceptance
        drive(1'b1, 5'd4, 1'b1, 2'b00, 32'h5555_0000, 32'd0, 3'd0, 2'd0, 1'b1, 1'b0, 32'd0);
        step();

        // flush coincident with the load response
        drive(1'b1, 5'd9, 1'b1, 2'b01, 32'd0, 32'd0, 3'b010, 2'd0, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, 1'b1, 1'b1, 32'h1111_2222);
        step();
        idle();
        step();

        // asynchronous reset in the middle of a load
        drive(1'b1, 5'd9, 1'b1, 2'b00, 32'hA5A5_0F0F, 32'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b1, 5'd10, 1'b1, 2'b01, 32'd0, 32'd0, 3'b010, 2'd0, 1'b0, 1'b0, 32'd0);
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midload_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 1'b1, 32'h7777_7777);
            step();
        end

`ifdef WB_INSTRET_EN
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(i + 1), 1'b1, 2'(i % 2 * 2), 32'(i), 32'(i), 3'd0, 2'd0, 1'b0, 1'b0, 32'd0);
            step();
        end
        drive(1'b1, 5'd2, 1'b1, 2'b01, 32'd0, 32'd0, 3'b000, 2'd0, 1'b0, 1'b0, 32'd0);
        step();
        drive(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 3'd0, 2'd0, 1'b1, 1'b0, 32'd0);
        step();
        chk("ex_instret", instret, 64'd10);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom),
                  2'($urandom),
                  $urandom,
                  $urandom,
                  3'($urandom),
                  2'($urandom),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 4,
                  $urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports, clock and reset first, as listed in REQ-002..REQ-019; one clock, reset asynchronous active-low.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  upstream (MEM) presents a retiring instruction.
REQ-005 in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
REQ-006 in_rd  in  5  destination register index.
REQ-007 in_reg_write  in  1  instruction writes a register.
REQ-008 in_wb_sel  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 none.
REQ-009 in_alu_result  in  32  ALU result.
REQ-010 in_pc_plus4  in  32  link value.
REQ-011 in_funct3  in  3  load type.
REQ-012 in_addr_lo  in  2  load byte address bits [1:0].
REQ-013 flush  in  1  discard pending/offered instruction.
REQ-014 mem_rsp_valid  in  1  load data valid.
REQ-015 mem_rsp_data  in  32  aligned 32-bit memory word.
REQ-016 rd  out  5  register-file destination index.
REQ-017 rd_data  out  32  register-file write data.
REQ-018 reg_write  out  1  register-file write enable, one-cycle pulse per retired write.
REQ-019 err_misaligned  out  1  one-cycle pulse on misaligned or illegal load.

Function
REQ-020 SHALL implement FSM states IDLE and WAIT_LOAD; in_ready = 1 in IDLE and not flush, 0 in WAIT_LOAD.
REQ-021 Accept in IDLE, wb_sel 00/10: next cycle reg_write = in_reg_write, rd_data = ALU/PC+4, rd = in_rd; latency exactly 1 cycle.
REQ-022 Accept in IDLE, wb_sel 11: no write, no error, stay IDLE.
REQ-023 Accept in IDLE, wb_sel 01: capture rd/funct3/addr_lo/reg_write, go WAIT_LOAD.
REQ-024 WAIT_LOAD with mem_rsp_valid: format data, next cycle reg_write pulse with formatted data, return to IDLE (in_ready = 1 that cycle).
REQ-025 mem_rsp_valid in IDLE SHALL be ignored.
REQ-026 Load format: LB(000)/LBU(100) byte lane addr_lo, sign/zero-extend; LH(001)/LHU(101) half lane addr_lo[1], sign/zero-extend; LW(010) full word.
REQ-027 LH/LHU with addr_lo[0]=1, LW with addr_lo != 0, or funct3 outside REQ-026: no write, err_misaligned pulse in the cycle reg_write would have pulsed.
REQ-028 reg_write SHALL be forced 0 when rd = 0; rd_data still driven.
REQ-029 flush in IDLE blocks acceptance that cycle; flush in WAIT_LOAD returns to IDLE with no write and no error, even if mem_rsp_valid same cycle.
REQ-030 All outputs registered; reg_write and err_misaligned 0 on every cycle without a retirement.

Reset
REQ-031 rst_n low: state IDLE, rd = 0, rd_data = 0, reg_write = 0, err_misaligned = 0 immediately, independent of clk.
REQ-032 Reset during WAIT_LOAD abandons the load; no write after release.
REQ-033 First acceptance possible on first rising edge after rst_n rises.

Configuration
REQ-034 Macro WB_INSTRET_EN SHALL add output instret (64 bits, reset 0), incremented by 1 per instruction retired (write, wb_sel 11, or erroring load counted; flushed not counted).
REQ-035 Without WB_INSTRET_EN: no instret port, no counter logic; all other behaviour identical.

Structure
REQ-036 Shared package riscv_pkg SHALL hold wb_sel encodings, load funct3 constants, FSM state type.
REQ-037 Combinational sub-module load_extend (word, funct3, addr_lo -> data, err) SHALL perform REQ-026/027.

Verification
REQ-038 ALU: accept rd=5, alu=0x0000_1234, sel 00 -> next cycle reg_write=1, rd=5, rd_data=0x0000_1234.
REQ-039 LB addr_lo=3, rsp after 3 cycles 0x80FF_0000 -> in_ready 0 for 3 cycles, then rd_data=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-040 LH addr_lo=1 -> no write, err_misaligned=1 one cycle; LHU addr_lo=2, data 0x8001_0000 -> 0x0000_8001.
REQ-041 rd=0 ALU write -> reg_write stays 0; JAL sel 10, pc_plus4=0x104, rd=1 -> rd_data=0x104.
REQ-042 Flush in WAIT_LOAD coincident with mem_rsp_valid -> no write, IDLE next cycle; rst_n low mid-load -> outputs 0 immediately.
REQ-043 With WB_INSTRET_EN: 10 accepted instructions, 1 flushed load -> instret = 10.
